// File: rtl/t09_sound_pkg.sv
// Shared definitions for the sound PWM output path: sample width and
// playback state encoding.
package t09_sound_pkg;

    localparam int SOUND_W = 8;

    typedef enum logic [1:0] {
        MUTED    = 2'd0,
        FADE_IN  = 2'd1,
        ACTIVE   = 2'd2,
        FADE_OUT = 2'd3
    } snd_state_e;

endpackage

// File: rtl/t09_sound_pwm_out_if.sv
// Sound sample bus (soundOut): the generator drives a sample and an
// enable; the PWM output stage consumes them.
interface t09_sound_pwm_out_if
    import t09_sound_pkg::*;
#(
    parameter int N = SOUND_W
);
    logic [N-1:0] sample_i;
    logic         enable_i;

    modport master (output sample_i, output enable_i);
    modport slave  (input  sample_i, input  enable_i);

endinterface

// File: rtl/t09_pwm_timebase.sv
// PWM timebase: a prescaler dividing the clock into count steps and an
// N-bit PWM counter. Flags the last cycle of each PWM period.
module t09_pwm_timebase
    import t09_sound_pkg::*;
#(
    parameter int N        = SOUND_W,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         nRst,
    output logic [N-1:0] pwm_cnt_next_o,
    output logic         boundary_o
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [N-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic            tick;

    assign tick           = (prescaler_q == PS_LAST);
    assign boundary_o     = tick && (pwm_cnt_q == '1);
    assign pwm_cnt_next_o = pwm_cnt_d;

    // Next count: prescaler wraps at PRESCALE-1, PWM counter steps on tick.
    always_comb begin
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    // Counter registers, cleared by reset so a period starts at release.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            prescaler_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

endmodule

// File: rtl/t09_sound_pwm_out.sv
// Sound PWM output stage: latches one sample per PWM period, fades the
// level in and out on enable changes, and drives a registered PWM pin.
module t09_sound_pwm_out
    import t09_sound_pkg::*;
#(
    parameter int N         = SOUND_W,
    parameter int PRESCALE  = 4,
    parameter int FADE_STEP = 1
) (
    input  logic                      clk,
    input  logic                      nRst,
    t09_sound_pwm_out_if.slave        snd_if,
    output logic                      pwm_o,
    output logic                      period_start_o,
    output logic [N-1:0]              level_o,
    output logic                      muted_o
);

    localparam logic [N:0] STEP = (N + 1)'(FADE_STEP);

    logic [N-1:0] pwm_cnt_next;
    logic         boundary;
    logic [N-1:0] sample;
    logic         enable;
    snd_state_e   state_q, state_d;
    logic [N-1:0] level_q, level_d;
    logic         pwm_q, pwm_d;
    logic         pstart_q, pstart_d;

    assign sample = snd_if.sample_i;
    assign enable = snd_if.enable_i;

    t09_pwm_timebase #(
        .N        (N),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk            (clk),
        .nRst           (nRst),
        .pwm_cnt_next_o (pwm_cnt_next),
        .boundary_o     (boundary)
    );

    // One fade step from cur toward tgt, computed one bit wider and clamped
    // at tgt so the level can neither overshoot nor wrap.
    function automatic logic [N-1:0] step_toward(input logic [N-1:0] cur,
                                                 input logic [N-1:0] tgt);
        logic [N:0] wide;
        if (tgt > cur) begin
            wide = {1'b0, cur} + STEP;
            return (wide > {1'b0, tgt}) ? tgt : wide[N-1:0];
        end
        wide = {1'b0, cur} - STEP;
        return (wide[N] || (wide[N-1:0] < tgt)) ? tgt : wide[N-1:0];
    endfunction

    // One fade-out step, saturating at zero (borrow bit flags underflow).
    function automatic logic [N-1:0] step_down(input logic [N-1:0] cur);
        logic [N:0] wide;
        wide = {1'b0, cur} - STEP;
        return wide[N] ? '0 : wide[N-1:0];
    endfunction

    // Playback FSM and level arithmetic; only the period boundary moves them.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (boundary) begin
            case (state_q)
                MUTED: begin
                    level_d = '0;
                    if (enable) begin
                        // Entering the fade and taking its first step share this edge.
                        level_d = step_toward('0, sample);
                        state_d = (level_d == sample) ? ACTIVE : FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (!enable) begin
                        state_d = FADE_OUT;
                    end else begin
                        level_d = step_toward(level_q, sample);
                        if (level_d == sample) state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!enable) state_d = FADE_OUT;
                    else         level_d = sample;
                end
                FADE_OUT: begin
                    if (enable) begin
                        state_d = FADE_IN;
                    end else begin
                        level_d = step_down(level_q);
                        if (level_d == '0) state_d = MUTED;
                    end
                end
                default: begin
                    state_d = MUTED;
                    level_d = '0;
                end
            endcase
        end
        // Compare against next-cycle count and level so the pin is registered
        // yet aligned with the counter it is derived from.
        pwm_d    = (pwm_cnt_next < level_d);
        pstart_d = boundary;
    end

    // State, level and output registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= MUTED;
            level_q  <= '0;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
        end
    end

    assign pwm_o          = pwm_q;
    assign period_start_o = pstart_q;
    assign level_o        = level_q;
    assign muted_o        = (state_q == MUTED);

endmodule

// File: tb/tb_t09_sound_pwm_out.sv
// Bench for t09_sound_pwm_out: three instances (step 1, step 16, default
// prescale 4) share one stimulus stream and are compared every cycle
// against a period-level behavioural model.
module tb_t09_sound_pwm_out;

    localparam int ND   = 3;
    localparam int S_M  = 0;
    localparam int S_FI = 1;
    localparam int S_A  = 2;
    localparam int S_FO = 3;

    function automatic int pre_of(int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic int step_of(int i);
        return (i == 1) ? 16 : 1;
    endfunction

    logic       clk    = 1'b0;
    logic       nRst   = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       enable = 1'b0;

    logic       pwm [ND];
    logic       pst [ND];
    logic [7:0] lvl [ND];
    logic       mut [ND];

    t09_sound_pwm_out_if #(.N(8)) if0 ();
    t09_sound_pwm_out_if #(.N(8)) if1 ();
    t09_sound_pwm_out_if #(.N(8)) if2 ();

    assign if0.sample_i = sample;
    assign if0.enable_i = enable;
    assign if1.sample_i = sample;
    assign if1.enable_i = enable;
    assign if2.sample_i = sample;
    assign if2.enable_i = enable;

    t09_sound_pwm_out #(.N(8), .PRESCALE(1), .FADE_STEP(1)) u0 (
        .clk(clk), .nRst(nRst), .snd_if(if0.slave),
        .pwm_o(pwm[0]), .period_start_o(pst[0]), .level_o(lvl[0]), .muted_o(mut[0]));
    t09_sound_pwm_out #(.N(8), .PRESCALE(1), .FADE_STEP(16)) u1 (
        .clk(clk), .nRst(nRst), .snd_if(if1.slave),
        .pwm_o(pwm[1]), .period_start_o(pst[1]), .level_o(lvl[1]), .muted_o(mut[1]));
    t09_sound_pwm_out #(.N(8), .PRESCALE(4), .FADE_STEP(1)) u2 (
        .clk(clk), .nRst(nRst), .snd_if(if2.slave),
        .pwm_o(pwm[2]), .period_start_o(pst[2]), .level_o(lvl[2]), .muted_o(mut[2]));

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0d got %0d expected %0d", nm, i, t, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int t;            // cycles since reset release
    int mst [ND];
    int mlv [ND];
    int nx  [ND];

    function automatic int toward(int cur, int tgt, int stp);
        if (tgt > cur) return (cur + stp > tgt) ? tgt : cur + stp;
        return (cur - stp < tgt) ? tgt : cur - stp;
    endfunction

    // Returns state*65536 + level after the current cycle's clock edge.
    function automatic int model_next(int i);
        int per = pre_of(i) * 256;
        int st  = mst[i];
        int lv  = mlv[i];
        int smp = int'(sample);
        int stp = step_of(i);
        if (t % per == per - 1) begin
            case (st)
                S_M: begin
                    if (enable) begin
                        lv = toward(0, smp, stp);
                        st = (lv == smp) ? S_A : S_FI;
                    end else lv = 0;
                end
                S_FI: begin
                    if (!enable) st = S_FO;
                    else begin
                        lv = toward(lv, smp, stp);
                        if (lv == smp) st = S_A;
                    end
                end
                S_A: begin
                    if (!enable) st = S_FO;
                    else lv = smp;
                end
                default: begin
                    if (enable) st = S_FI;
                    else begin
                        lv = (lv > stp) ? lv - stp : 0;
                        if (lv == 0) st = S_M;
                    end
                end
            endcase
        end
        return st * 65536 + lv;
    endfunction

    initial begin
        t = 0;
        for (int i = 0; i < ND; i++) begin mst[i] = S_M; mlv[i] = 0; end
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) begin
                t = 0;
                for (int i = 0; i < ND; i++) begin mst[i] = S_M; mlv[i] = 0; end
            end else begin
                for (int i = 0; i < ND; i++) nx[i] = model_next(i);
                for (int i = 0; i < ND; i++) begin
                    mst[i] = nx[i] / 65536;
                    mlv[i] = nx[i] % 65536;
                end
                t = t + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            int per, ph;
            per = pre_of(i) * 256;
            ph  = t % per;
            if (!nRst) begin
                chk("rst_pwm", i, int'(pwm[i]), 0);
                chk("rst_pstart", i, int'(pst[i]), 0);
                chk("rst_level", i, int'(lvl[i]), 0);
                chk("rst_muted", i, int'(mut[i]), 1);
            end else begin
                chk("pwm", i, int'(pwm[i]), int'((ph / pre_of(i)) < mlv[i]));
                chk("pstart", i, int'(pst[i]), int'(ph == 0 && t != 0));
                chk("level", i, int'(lvl[i]), mlv[i]);
                chk("muted", i, int'(mut[i]), int'(mst[i] == S_M));
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic wait_t(int tt);
        int g = 0;
        while (t < tt && g < 30000) begin @(negedge clk); g++; end
        chk("timeline", 0, t, tt);
    endtask

    task automatic lit(int i, int exp_lvl, int exp_mut);
        chk("lit_level", i, int'(lvl[i]), exp_lvl);
        chk("lit_muted", i, int'(mut[i]), exp_mut);
    endtask

    task automatic count_high(int n, output int c0, output int c1);
        c0 = 0; c1 = 0;
        repeat (n) begin
            c0 += int'(pwm[0]);
            c1 += int'(pwm[1]);
            @(negedge clk);
        end
    endtask

    initial begin
        int a0, a1, b0, b1, k;
        repeat (3) @(negedge clk);
        nRst = 1'b1; enable = 1'b1; sample = 8'd3;

        // Fade in to 3 from mute
        wait_t(256);  lit(0, 1, 0); lit(1, 3, 0);
        wait_t(512);  lit(0, 2, 0);
        wait_t(768);  lit(0, 3, 0);
        count_high(256, a0, a1);
        chk("duty3", 0, a0, 3);

        // Silence, then full scale
        wait_t(1030); sample = 8'd0;
        wait_t(1280);
        count_high(10, a0, a1);
        sample = 8'd255;
        count_high(246, b0, b1);
        chk("duty0", 0, a0 + b0, 0);
        chk("duty0", 1, a1 + b1, 0);
        count_high(256, a0, a1);
        chk("duty255", 0, a0, 255);
        chk("duty255", 1, a1, 255);

        // Fade out from 5 to mute
        wait_t(1800); sample = 8'd5;
        wait_t(2048); lit(0, 5, 0);
        wait_t(2100); enable = 1'b0;
        wait_t(2304); lit(0, 5, 0); lit(1, 5, 0);
        wait_t(2560); lit(0, 4, 0); lit(1, 0, 1);
        wait_t(3328); lit(0, 1, 0);
        wait_t(3583); lit(0, 1, 0);
        wait_t(3584); lit(0, 0, 1);

        // Fade back up, fade down, re-enable at level 2
        wait_t(3600); enable = 1'b1;
        wait_t(4900); enable = 1'b0;
        wait_t(5888); lit(0, 2, 0);
        wait_t(5900); enable = 1'b1;
        wait_t(6144); lit(0, 2, 0);
        wait_t(6400); lit(0, 3, 0);
        wait_t(6912); lit(0, 5, 0);

        // Sample toggling inside a period only lands at the boundary
        wait_t(7000); sample = 8'd10;
        wait_t(7100); sample = 8'd200;
        wait_t(7150); sample = 8'd10;
        wait_t(7167); lit(0, 5, 0); chk("lit_pstart", 0, int'(pst[0]), 0);
        wait_t(7168); lit(0, 10, 0); chk("lit_pstart", 0, int'(pst[0]), 1);
        wait_t(7200); sample = 8'd200;
        wait_t(7300); sample = 8'd10;
        wait_t(7400); sample = 8'd200;
        wait_t(7423); lit(0, 10, 0);
        wait_t(7424); lit(0, 200, 0); chk("lit_pstart", 0, int'(pst[0]), 1);

        // Large step: clamp at 255 on the way up, saturate at 0 on the way down
        wait_t(7500); sample = 8'd250;
        wait_t(7680); lit(0, 250, 0); lit(1, 250, 0);
        wait_t(7700); enable = 1'b0;
        wait_t(7936); lit(1, 250, 0);
        wait_t(7950); enable = 1'b1; sample = 8'd255;
        wait_t(8192); lit(1, 250, 0);
        wait_t(8448); lit(1, 255, 0); lit(0, 251, 0);
        wait_t(8500); sample = 8'd10;
        wait_t(8704); lit(1, 10, 0);
        wait_t(8800); enable = 1'b0;
        wait_t(8960); lit(1, 10, 0);
        wait_t(9216); lit(1, 0, 1);
        wait_t(9300); enable = 1'b1; sample = 8'd100;
        wait_t(11008); lit(1, 100, 0);

        // Asynchronous reset in mid-period
        wait_t(11100);
        #2 nRst = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            chk("async_pwm", i, int'(pwm[i]), 0);
            chk("async_pstart", i, int'(pst[i]), 0);
            chk("async_level", i, int'(lvl[i]), 0);
            chk("async_muted", i, int'(mut[i]), 1);
        end
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        k = 0;
        while (k < 600 && pst[0] !== 1'b1) begin @(negedge clk); k++; end
        chk("first_pulse", 0, k, 256);

        // Randomised enable/sample traffic, checked by the model
        repeat (80) begin
            repeat ($urandom_range(5, 400)) @(negedge clk);
            enable = ($urandom_range(0, 3) != 0);
            sample = 8'($urandom);
            if ($urandom_range(0, 5) == 0) sample = 8'd0;
            if ($urandom_range(0, 5) == 0) sample = 8'd255;
        end
        repeat (2100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
